// File: rtl/butterfly_addr_gen.sv
// Radix-2 in-place FFT butterfly address generator: walks every (stage, butterfly)
// pair of one pass, handing out operand addresses, twiddle index and load-phase selector.
module butterfly_addr_gen #(
    parameter int LOG2N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             advance,
    output logic [9:0]       a_real,
    output logic [9:0]       a_imag,
    output logic [9:0]       b_real,
    output logic [9:0]       b_imag,
    output logic [LOG2N-2:0] twiddle_idx,
    output logic [2:0]       samples_loaded_count,
    output logic [2:0]       stage,
    output logic             busy,
    output logic             fft_done
);

    localparam logic [LOG2N-2:0] K_LAST     = '1;
    localparam logic [LOG2N-2:0] K_ONE      = (LOG2N-1)'(1);
    localparam logic [LOG2N-1:0] IDX_ONE    = LOG2N'(1);
    localparam logic [2:0]       STAGE_LAST = 3'(LOG2N - 1);
    localparam logic [2:0]       TW_TOP     = 3'(LOG2N - 1);
    localparam logic [9:0]       IMAG_BASE  = 10'(1 << LOG2N);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    state_t           state_q;
    logic [2:0]       stage_q, stage_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [2:0]       count_q;
    logic [9:0]       aReal_q, aImag_q, bReal_q, bImag_q;
    logic [LOG2N-2:0] twiddle_q, twiddle_d;
    logic             busy_q, done_q;
    logic [LOG2N-1:0] kExt, posMask, pos, idxA_d, idxB_d, twFull;

    // Butterfly that will be presented on the next LOAD entry, and its addresses.
    always_comb begin
        stage_d = stage_q;
        k_d     = k_q;
        if (state_q == IDLE) begin
            stage_d = '0;
            k_d     = '0;
        end else if (k_q == K_LAST) begin
            stage_d = stage_q + 3'd1;
            k_d     = '0;
        end else begin
            k_d = k_q + K_ONE;
        end
        kExt      = {1'b0, k_d};
        posMask   = (IDX_ONE << stage_d) - IDX_ONE;
        pos       = kExt & posMask;
        idxA_d    = (((kExt >> stage_d) << stage_d) << 1) | pos;
        idxB_d    = idxA_d | (IDX_ONE << stage_d);
        twFull    = pos << (TW_TOP - stage_d);
        twiddle_d = twFull[LOG2N-2:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            k_q       <= '0;
            count_q   <= 3'd7;
            aReal_q   <= '0;
            aImag_q   <= '0;
            bReal_q   <= '0;
            bImag_q   <= '0;
            twiddle_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= LOAD;
                        stage_q   <= stage_d;
                        k_q       <= k_d;
                        count_q   <= 3'd0;
                        aReal_q   <= 10'(idxA_d);
                        aImag_q   <= 10'(idxA_d) | IMAG_BASE;
                        bReal_q   <= 10'(idxB_d);
                        bImag_q   <= 10'(idxB_d) | IMAG_BASE;
                        twiddle_q <= twiddle_d;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (count_q == 3'd3) begin
                        state_q <= WAIT;
                    end
                    count_q <= count_q + 3'd1;
                end
                WAIT: begin
                    // Advance has priority over start here; start is simply not looked at.
                    if (advance) begin
                        if (stage_q == STAGE_LAST && k_q == K_LAST) begin
                            state_q <= DONE;
                            count_q <= 3'd7;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= LOAD;
                            stage_q   <= stage_d;
                            k_q       <= k_d;
                            count_q   <= 3'd0;
                            aReal_q   <= 10'(idxA_d);
                            aImag_q   <= 10'(idxA_d) | IMAG_BASE;
                            bReal_q   <= 10'(idxB_d);
                            bImag_q   <= 10'(idxB_d) | IMAG_BASE;
                            twiddle_q <= twiddle_d;
                        end
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    stage_q   <= '0;
                    k_q       <= '0;
                    aReal_q   <= '0;
                    aImag_q   <= '0;
                    bReal_q   <= '0;
                    bImag_q   <= '0;
                    twiddle_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_real               = aReal_q;
    assign a_imag               = aImag_q;
    assign b_real               = bReal_q;
    assign b_imag               = bImag_q;
    assign twiddle_idx          = twiddle_q;
    assign samples_loaded_count = count_q;
    assign stage                = stage_q;
    assign busy                 = busy_q;
    assign fft_done             = done_q;

endmodule

// File: doc/butterfly_addr_gen.md
BUTTERFLY_ADDR_GEN -- requirements
Module: butterfly_addr_gen

Interface
REQ-001 The block SHALL have parameter LOG2N, default 8, meaning log2 of FFT length N (N = 256 at default).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin one full FFT pass.
REQ-005 The block SHALL have port advance, input, 1, asserted when the consumer has finished the current butterfly.
REQ-006 The block SHALL have ports a_real, a_imag, b_real, b_imag, output, 10 each, the memory addresses of the butterfly operands.
REQ-007 The block SHALL have port twiddle_idx, output, LOG2N-1, the twiddle ROM index for the current butterfly.
REQ-008 The block SHALL have port samples_loaded_count, output, 3, the load-phase selector for the downstream address sequencer.
REQ-009 The block SHALL have port stage, output, 3, the current FFT stage s, range 0..LOG2N-1.
REQ-010 The block SHALL have port busy, output, 1, high in LOAD and WAIT.
REQ-011 The block SHALL have port fft_done, output, 1, a one-cycle completion pulse.

Function
REQ-012 The block SHALL implement states IDLE, LOAD, WAIT and DONE.
REQ-013 IDLE SHALL go to LOAD on the cycle after start=1, with stage=0, butterfly k=0 and samples_loaded_count=0.
REQ-014 In LOAD, samples_loaded_count SHALL step 0,1,2,3 on consecutive cycles; after 3 the state SHALL go to WAIT with count=4.
REQ-015 In WAIT, addresses SHALL hold stable until advance=1.
REQ-016 On advance in WAIT, k SHALL increment and the state SHALL re-enter LOAD with count=0.
REQ-017 When k=N/2-1 the stage SHALL increment and k SHALL wrap to 0.
REQ-018 When stage=LOG2N-1 and k=N/2-1, advance SHALL go to DONE instead of LOAD.
REQ-019 DONE SHALL last one cycle with fft_done=1, then go to IDLE.
REQ-020 In IDLE and DONE, samples_loaded_count SHALL be 7, so the downstream selects address 0.
REQ-021 Indexing SHALL be radix-2 in-place: span=2^s, group=k>>s, pos=k&(span-1), ia=group*2*span+pos, ib=ia+span.
REQ-022 twiddle_idx SHALL equal pos<<(LOG2N-1-s), truncated to LOG2N-1 bits.
REQ-023 Real addresses SHALL be {2'b00,index} and imaginary addresses SHALL be {2'b01,index}, zero-extended to 10 bits; at default, imag = real + 256.
REQ-024 Address and twiddle outputs SHALL be registered, valid from the first LOAD cycle, and stable through LOAD and WAIT of one butterfly.
REQ-025 advance SHALL be ignored in IDLE, LOAD and DONE.
REQ-026 start SHALL be ignored in every state except IDLE.
REQ-027 When start and advance are both high in WAIT, advance SHALL be honoured and start ignored.
REQ-028 One pass SHALL consume exactly LOG2N*N/2 advances (1024 at default).

Reset
REQ-029 On rst=1 at a clock edge, the state SHALL go to IDLE regardless of current state, including mid-pass.
REQ-030 On reset, all addresses, twiddle_idx, stage, k, busy and fft_done SHALL be 0, and samples_loaded_count SHALL be 7.
REQ-031 rst SHALL have priority over start and advance in the same cycle.

Verification
REQ-032 Bench SHALL cover: rst held 2 cycles -> all outputs 0, samples_loaded_count=7, busy=0.
REQ-033 Bench SHALL cover: start pulse -> next cycle a_real=0, a_imag=256, b_real=1, b_imag=257, twiddle_idx=0; count 0,1,2,3 then 4 and held.
REQ-034 Bench SHALL cover: drive to stage=2, k=5 -> a_real=9, b_real=13, b_imag=269, twiddle_idx=32.
REQ-035 Bench SHALL cover: stage=7, k=127 -> a_real=127, b_real=255, twiddle_idx=127; advance -> fft_done high exactly one cycle, then IDLE with busy=0, after 1024 total advances.
REQ-036 Bench SHALL cover: advance pulsed during LOAD count=1, and start pulsed in WAIT -> neither changes k or stage; count sequence unchanged.
REQ-037 Bench SHALL cover: rst asserted in WAIT at stage=3 -> next cycle IDLE with reset values; a new start restarts at stage=0, k=0.
